spi_frame_arbiter: RTL

- Shares a single SPI byte transmitter between two requesters.
  - The transmitter is the CPOL=0/CPHA=0, MSB-first, chip-select-driven byte engine.
  - Each requester sends multi-byte frames of 1–15 bytes.
- The block arbitrates round-robin and frames each transfer with chip-select.
- It feeds bytes one at a time, advancing on the transmitter's end-of-byte pulse.
- It enforces a minimum chip-select-high gap between frames.
- It sits between the display/status producers and the transmitter in the SPI subsystem.

---
 rtl/spi_frame_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/spi_frame_arbiter.sv
// Round-robin arbiter that shares one SPI byte transmitter between two frame
// requesters, framing each transfer with chip-select and a minimum CS-high gap.
module spi_frame_arbiter #(
   parameter int unsigned CS_GAP = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] len0,
   input  logic [3:0] len1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       done0,
   output logic       done1,
   output logic [1:0] grant,
   output logic       busy,
   output logic [7:0] tx_data,
   output logic       tx_cs,
   input  logic       tx_valid
);

   localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] gap_q, gap_d;
   logic [1:0] grant_q, grant_d;
   logic [1:0] ack_q, ack_d;
   logic [1:0] done_q, done_d;
   logic       last_q, last_d;   // 1 = requester 1 owned the last frame
   logic       busy_q, busy_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_cs_q, tx_cs_d;

   logic eff0, eff1, pick1;
   logic [7:0] owner_data;

   assign eff0  = req0 && (len0 != 4'd0);
   assign eff1  = req1 && (len1 != 4'd0);
   // On a tie the requester that did not own the previous frame wins.
   assign pick1 = eff1 && (!eff0 || !last_q);
   assign owner_data = grant_q[1] ? data1 : data0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      grant_d   = grant_q;
      ack_d     = 2'b00;
      done_d    = 2'b00;
      last_d    = last_q;
      busy_d    = busy_q;
      tx_data_d = tx_data_q;
      tx_cs_d   = tx_cs_q;
      case (state_q)
         S_IDLE: begin
            if (eff0 || eff1) begin
               grant_d   = pick1 ? 2'b10 : 2'b01;
               ack_d     = pick1 ? 2'b10 : 2'b01;
               cnt_d     = pick1 ? len1 : len0;
               tx_data_d = pick1 ? data1 : data0;
               last_d    = pick1;
               tx_cs_d   = 1'b0;
               busy_d    = 1'b1;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            if (tx_valid) begin
               if (cnt_q > 4'd1) begin
                  cnt_d     = cnt_q - 4'd1;
                  tx_data_d = owner_data;
                  ack_d     = grant_q;
               end else begin
                  cnt_d   = 4'd0;
                  tx_cs_d = 1'b1;
                  done_d  = grant_q;
                  grant_d = 2'b00;
                  gap_d   = GAP_LOAD;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            // Leaving one cycle early lets the next grant land exactly CS_GAP
            // edges after the final byte, so tx_cs is high for CS_GAP cycles.
            if (gap_q <= 8'd1) begin
               gap_d   = 8'd0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         gap_q     <= 8'd0;
         grant_q   <= 2'b00;
         ack_q     <= 2'b00;
         done_q    <= 2'b00;
         last_q    <= 1'b1;
         busy_q    <= 1'b0;
         tx_data_q <= 8'h00;
         tx_cs_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         tx_data_q <= tx_data_d;
         tx_cs_q   <= tx_cs_d;
      end
   end

   assign ack0    = ack_q[0];
   assign ack1    = ack_q[1];
   assign done0   = done_q[0];
   assign done1   = done_q[1];
   assign grant   = grant_q;
   assign busy    = busy_q;
   assign tx_data = tx_data_q;
   assign tx_cs   = tx_cs_q;

endmodule
